reduce_tree_pipe: RTL and testbench



---
 rtl/reduce_pkg.sv | 51 +++++
 rtl/reduce_level.sv | 23 ++
 rtl/reduce_tree_pipe.sv | 118 +++++++++++
 tb/tb_reduce_tree_pipe.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reduce_pkg.sv
// Shared op encodings and constant helpers for the pipelined reduction tree.
package reduce_pkg;

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_NOR = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  // Neutral element of the underlying gate: 1 for AND, 0 for OR/NOR/XOR.
  function automatic logic identity_bit(logic [1:0] op);
    return (op == OP_AND);
  endfunction

  // NOR reduces as OR; the inversion is applied once at the last level.
  function automatic logic combine2(logic [1:0] op, logic a, logic b);
    case (op)
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      default: return a | b;
    endcase
  endfunction

  function automatic int unsigned clog2(int unsigned v);
    int unsigned r = 0;
    int unsigned p = 1;
    while (p < v) begin
      p = p << 1;
      r++;
    end
    return r;
  endfunction

  // Number of nodes left after lvl tree levels.
  function automatic int unsigned node_cnt(int unsigned width, int unsigned lvl);
    int unsigned n = width;
    for (int unsigned j = 0; j < lvl; j++) begin
      n = (n + 1) / 2;
    end
    return n;
  endfunction

  // Bit offset of level lvl inside the flattened node bus.
  function automatic int unsigned node_off(int unsigned width, int unsigned lvl);
    int unsigned off = 0;
    for (int unsigned j = 0; j < lvl; j++) begin
      off += node_cnt(width, j);
    end
    return off;
  endfunction

endpackage

// File: rtl/reduce_level.sv
// One combinational tree level: pairs of nodes are combined, an odd last node passes through.
module reduce_level
  import reduce_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [1:0]         op_i,
  input  logic [N-1:0]       d_i,
  output logic [(N+1)/2-1:0] d_o
);

  localparam int unsigned Pairs = N / 2;

  for (genvar i = 0; i < Pairs; i++) begin : g_pair
    assign d_o[i] = combine2(op_i, d_i[2*i], d_i[2*i+1]);
  end

  // Passing the leftover through is equivalent to pairing it with identity_bit(op).
  if ((N % 2) == 1) begin : g_odd
    assign d_o[Pairs] = d_i[N-1];
  end

endmodule

// File: rtl/reduce_tree_pipe.sv
// Pipelined WIDTH-to-1 OR/NOR/AND/XOR reduction with valid/ready handshake and sideband tag.
// A register bank follows every REG_EVERY levels and the final level; the last bank drives out_*.
module reduce_tree_pipe
  import reduce_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned REG_EVERY = 2,
  parameter int unsigned TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_z,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned LEVELS     = clog2(WIDTH);
  localparam int unsigned TotalNodes = node_off(WIDTH, LEVELS) + 1;

  // Level k occupies tree[node_off(WIDTH, k) +: node_cnt(WIDTH, k)]; level 0 is the operand.
  logic [TotalNodes-1:0] tree;
  logic [1:0]            op_s  [LEVELS];
  logic [TAG_W-1:0]      tag_s [LEVELS+1];
  logic                  vld_s [LEVELS+1];
  logic                  stall;
  logic                  adv;

  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = rst_n & ~stall;

  assign tree[WIDTH-1:0] = in_data;
  assign op_s[0]         = in_op;
  assign tag_s[0]        = in_tag;
  assign vld_s[0]        = in_valid & in_ready;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int unsigned NIn    = node_cnt(WIDTH, k - 1);
    localparam int unsigned NOut   = node_cnt(WIDTH, k);
    localparam int unsigned OffIn  = node_off(WIDTH, k - 1);
    localparam int unsigned OffOut = node_off(WIDTH, k);
    localparam bit          IsLast = (k == LEVELS);
    localparam bit          HasReg = ((k % REG_EVERY) == 0) || IsLast;

    logic [NOut-1:0] lvl_c;
    logic [NOut-1:0] node_d;

    reduce_level #(
      .N(NIn)
    ) u_level (
      .op_i(op_s[k-1]),
      .d_i (tree[OffIn +: NIn]),
      .d_o (lvl_c)
    );

    if (IsLast) begin : g_inv
      assign node_d = lvl_c ^ {NOut{op_s[k-1] == OP_NOR}};
    end else begin : g_noinv
      assign node_d = lvl_c;
    end

    if (HasReg) begin : g_bank
      logic [NOut-1:0]  node_q;
      logic [TAG_W-1:0] tag_q;
      logic             vld_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          node_q <= '0;
          tag_q  <= '0;
          vld_q  <= 1'b0;
        end else if (adv) begin
          node_q <= node_d;
          tag_q  <= tag_s[k-1];
          vld_q  <= vld_s[k-1];
        end
      end

      assign tree[OffOut +: NOut] = node_q;
      assign tag_s[k]             = tag_q;
      assign vld_s[k]             = vld_q;
    end else begin : g_wire
      assign tree[OffOut +: NOut] = node_d;
      assign tag_s[k]             = tag_s[k-1];
      assign vld_s[k]             = vld_s[k-1];
    end

    // The op is no longer needed once the final level has been evaluated.
    if (!IsLast) begin : g_op
      if (HasReg) begin : g_op_bank
        logic [1:0] op_q;

        always_ff @(posedge clk) begin
          if (!rst_n) begin
            op_q <= OP_OR;
          end else if (adv) begin
            op_q <= op_s[k-1];
          end
        end

        assign op_s[k] = op_q;
      end else begin : g_op_wire
        assign op_s[k] = op_s[k-1];
      end
    end
  end

  assign out_valid = vld_s[LEVELS];
  assign out_z     = tree[TotalNodes-1];
  assign out_tag   = tag_s[LEVELS];

endmodule

// File: tb/tb_reduce_tree_pipe.sv
// Directed self-checking bench: a 32-bit/REG_EVERY=2 instance and a 13-bit/REG_EVERY=1 instance.
module tb_reduce_tree_pipe;
  import reduce_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_z;
  logic [31:0] a_in_data;
  logic [1:0]  a_in_op;
  logic [3:0]  a_in_tag, a_out_tag;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_z;
  logic [12:0] b_in_data;
  logic [1:0]  b_in_op;
  logic [3:0]  b_in_tag, b_out_tag;

  int checks   = 0;
  int failures = 0;

  reduce_tree_pipe #(
    .WIDTH    (32),
    .REG_EVERY(2),
    .TAG_W    (4)
  ) u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (a_in_valid),
    .in_ready (a_in_ready),
    .in_data  (a_in_data),
    .in_op    (a_in_op),
    .in_tag   (a_in_tag),
    .out_valid(a_out_valid),
    .out_ready(a_out_ready),
    .out_z    (a_out_z),
    .out_tag  (a_out_tag)
  );

  reduce_tree_pipe #(
    .WIDTH    (13),
    .REG_EVERY(1),
    .TAG_W    (4)
  ) u_dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (b_in_valid),
    .in_ready (b_in_ready),
    .in_data  (b_in_data),
    .in_op    (b_in_op),
    .in_tag   (b_in_tag),
    .out_valid(b_out_valid),
    .out_ready(b_out_ready),
    .out_z    (b_out_z),
    .out_tag  (b_out_tag)
  );

  task automatic test_reset();
    rst_n      = 1'b0;
    a_in_valid = 1'b1;
    a_in_data  = 32'hFFFF_FFFF;
    a_in_op    = OP_AND;
    a_in_tag   = 4'hF;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (a_in_ready !== 1'b0) begin
        failures++;
        $display("FAIL reset_in_ready got=%b want=0", a_in_ready);
      end
      checks++;
      if (a_out_valid !== 1'b0 || a_out_z !== 1'b0 || a_out_tag !== 4'h0) begin
        failures++;
        $display("FAIL reset_outputs got v=%b z=%b tag=%h want v=0 z=0 tag=0",
                 a_out_valid, a_out_z, a_out_tag);
      end
      checks++;
      if (b_out_valid !== 1'b0 || b_in_ready !== 1'b0) begin
        failures++;
        $display("FAIL reset_b got v=%b rdy=%b want v=0 rdy=0", b_out_valid, b_in_ready);
      end
    end
    rst_n      = 1'b1;
    a_in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (a_out_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_release_valid got=%b want=0", a_out_valid);
      end
    end
  endtask

  task automatic test_ops();
    logic [31:0] vd [8] = '{32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0001_0000,
                            32'h8000_0001, 32'h0000_0400, 32'hFFFF_7FFF, 32'h0000_0100};
    logic [1:0]  vo [8] = '{OP_OR, OP_NOR, OP_AND, OP_XOR, OP_XOR, OP_NOR, OP_AND, OP_OR};
    logic        vz [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = vd[i];
      a_in_op    = vo[i];
      a_in_tag   = 4'(i + 1);
      @(negedge clk);
      a_in_valid = 1'b0;
      for (int j = 1; j < 3; j++) begin
        checks++;
        if (a_out_valid !== 1'b0) begin
          failures++;
          $display("FAIL ops_early_valid vec=%0d cyc=%0d got=%b want=0", i, j, a_out_valid);
        end
        @(negedge clk);
      end
      checks++;
      if (a_out_valid !== 1'b1 || a_out_z !== vz[i] || a_out_tag !== 4'(i + 1)) begin
        failures++;
        $display("FAIL ops_result vec=%0d got v=%b z=%b tag=%h want v=1 z=%b tag=%h",
                 i, a_out_valid, a_out_z, a_out_tag, vz[i], 4'(i + 1));
      end
      @(negedge clk);
      checks++;
      if (a_out_valid !== 1'b0) begin
        failures++;
        $display("FAIL ops_duplicate vec=%0d got v=%b want=0", i, a_out_valid);
      end
    end
  endtask

  task automatic test_npow2();
    logic [12:0] vd [5] = '{13'h1FFF, 13'h1FFE, 13'h1000, 13'h1001, 13'h0000};
    logic [1:0]  vo [5] = '{OP_AND, OP_AND, OP_OR, OP_XOR, OP_NOR};
    logic        vz [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = vd[i];
      b_in_op    = vo[i];
      b_in_tag   = 4'(i + 9);
      @(negedge clk);
      b_in_valid = 1'b0;
      for (int j = 1; j < 4; j++) begin
        checks++;
        if (b_out_valid !== 1'b0) begin
          failures++;
          $display("FAIL npow2_early_valid vec=%0d cyc=%0d got=%b want=0", i, j, b_out_valid);
        end
        @(negedge clk);
      end
      checks++;
      if (b_out_valid !== 1'b1 || b_out_z !== vz[i] || b_out_tag !== 4'(i + 9)) begin
        failures++;
        $display("FAIL npow2_result vec=%0d got v=%b z=%b tag=%h want v=1 z=%b tag=%h",
                 i, b_out_valid, b_out_z, b_out_tag, vz[i], 4'(i + 9));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    // XOR of the small integers 0..7: their parity.
    logic par [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int c = 0; c < 12; c++) begin
      if (c >= 3 && c < 11) begin
        checks++;
        if (a_out_valid !== 1'b1 || a_out_tag !== 4'(c - 3) || a_out_z !== par[c-3]) begin
          failures++;
          $display("FAIL stream_out cyc=%0d got v=%b z=%b tag=%h want v=1 z=%b tag=%h",
                   c, a_out_valid, a_out_z, a_out_tag, par[c-3], 4'(c - 3));
        end
      end else begin
        checks++;
        if (a_out_valid !== 1'b0) begin
          failures++;
          $display("FAIL stream_idle cyc=%0d got v=%b want=0", c, a_out_valid);
        end
      end
      checks++;
      if (a_in_ready !== 1'b1) begin
        failures++;
        $display("FAIL stream_in_ready cyc=%0d got=%b want=1", c, a_in_ready);
      end
      a_in_valid = (c < 8);
      a_in_data  = 32'(c);
      a_in_op    = OP_XOR;
      a_in_tag   = 4'(c);
      @(negedge clk);
    end
    a_in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic par [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int idx = 0;
    int rx  = 0;
    for (int c = 0; c < 17; c++) begin
      a_out_ready = !(c >= 4 && c <= 9);
      a_in_valid  = (idx < 5);
      a_in_data   = 32'(idx);
      a_in_op     = OP_XOR;
      a_in_tag    = 4'(idx + 8);
      #1;
      if (c >= 4 && c <= 9) begin
        checks++;
        if (a_in_ready !== 1'b0) begin
          failures++;
          $display("FAIL bp_in_ready cyc=%0d got=%b want=0", c, a_in_ready);
        end
        checks++;
        if (a_out_valid !== 1'b1 || a_out_tag !== 4'h9 || a_out_z !== 1'b1) begin
          failures++;
          $display("FAIL bp_hold cyc=%0d got v=%b z=%b tag=%h want v=1 z=1 tag=9",
                   c, a_out_valid, a_out_z, a_out_tag);
        end
      end
      if (a_out_valid === 1'b1 && a_out_ready) begin
        checks++;
        if (rx >= 5 || a_out_tag !== 4'(rx + 8) || a_out_z !== par[rx % 5]) begin
          failures++;
          $display("FAIL bp_order cyc=%0d rx=%0d got z=%b tag=%h want z=%b tag=%h",
                   c, rx, a_out_z, a_out_tag, par[rx % 5], 4'(rx + 8));
        end
        rx++;
      end
      if (a_in_valid && a_in_ready === 1'b1) idx++;
      @(negedge clk);
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    checks++;
    if (rx != 5 || idx != 5) begin
      failures++;
      $display("FAIL bp_count got rx=%0d sent=%0d want rx=5 sent=5", rx, idx);
    end
  endtask

  task automatic test_midflight_reset();
    for (int i = 0; i < 2; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 32'h0000_0000;
      a_in_op    = OP_NOR;
      a_in_tag   = 4'(i + 3);
      @(negedge clk);
    end
    a_in_valid = 1'b0;
    rst_n      = 1'b0;
    #1;
    checks++;
    if (a_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL midrst_in_ready got=%b want=0", a_in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (a_out_valid !== 1'b0) begin
        failures++;
        $display("FAIL midrst_valid cyc=%0d got=%b tag=%h want v=0", c, a_out_valid, a_out_tag);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    a_in_valid  = 1'b0;
    a_in_data   = '0;
    a_in_op     = OP_OR;
    a_in_tag    = '0;
    a_out_ready = 1'b1;
    b_in_valid  = 1'b0;
    b_in_data   = '0;
    b_in_op     = OP_OR;
    b_in_tag    = '0;
    b_out_ready = 1'b1;

    test_reset();
    test_ops();
    test_npow2();
    test_back_to_back();
    test_backpressure();
    test_midflight_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
